password_checker: RTL

- Downstream stage of the attempt-assembly block: consumes the assembled 16-bit unlock attempt (four 4-bit digits, MSB nibble first) and the stored password.
- On an Enter press it compares the two, drives unlock, counts consecutive failures and enforces a timed lockout after too many failures.
- Tells the upstream stage when to clear its attempt register.

---
 rtl/password_checker_pkg.sv | 22 ++
 rtl/password_checker_if.sv | 28 ++
 rtl/password_checker_cycle_timer.sv | 27 ++
 rtl/password_checker.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/password_checker_pkg.sv
// Shared definitions for the password checker: state encoding, blank-digit
// markers and the attempt-completeness helper.
package password_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    UNLOCKED = 3'd2,
    LOCKOUT  = 3'd3
  } check_state_t;

  localparam logic [3:0]  BLANK_NIBBLE  = 4'hF;
  localparam logic [15:0] EMPTY_ATTEMPT = 16'hFFFF;
  localparam int          TIMER_W       = 32;

  // True when any of the four digits has not been entered yet.
  function automatic logic has_blank(input logic [15:0] a);
    return (a[15:12] == BLANK_NIBBLE) || (a[11:8] == BLANK_NIBBLE) ||
           (a[7:4]   == BLANK_NIBBLE) || (a[3:0]  == BLANK_NIBBLE);
  endfunction

endpackage

// File: rtl/password_checker_if.sv
// Bundle between the attempt-assembly stage (master) and the checker (slave).
// Handshake: there is no valid/ready pair; the rising edge of enterButton is the
// request, and clearEntry is the one-cycle completion strobe back to the master.
interface password_checker_if;
  logic [15:0] passwordUnlockAttempt;
  logic [15:0] storedPassword;
  logic        enterButton;
  logic        lockButton;
  logic        unlocked;
  logic        lockedOut;
  logic        badAttempt;
  logic        incompleteEntry;
  logic        clearEntry;
  logic [2:0]  attemptsLeft;
  logic [2:0]  checkState;

  modport master (
    output passwordUnlockAttempt, storedPassword, enterButton, lockButton,
    input  unlocked, lockedOut, badAttempt, incompleteEntry, clearEntry,
           attemptsLeft, checkState
  );

  modport slave (
    input  passwordUnlockAttempt, storedPassword, enterButton, lockButton,
    output unlocked, lockedOut, badAttempt, incompleteEntry, clearEntry,
           attemptsLeft, checkState
  );
endinterface

// File: rtl/password_checker_cycle_timer.sv
// Loadable down-counter; o_expire flags the last counted cycle (count == 1).
module cycle_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_enable,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/password_checker.sv
// Unlock-attempt checker: compares on Enter, counts consecutive failures and
// enforces a timed lockout; all outputs are registered.
module password_checker
  import password_pkg::*;
#(
  parameter int MAX_ATTEMPTS       = 3,
  parameter int LOCKOUT_CYCLES     = 1000,
  parameter int UNLOCK_HOLD_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  password_checker_if.slave  bus
);

  localparam logic [2:0]         MAX_A     = 3'(MAX_ATTEMPTS);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(UNLOCK_HOLD_CYCLES);
  localparam bit                 HOLD_EN   = (UNLOCK_HOLD_CYCLES > 0);

  check_state_t r_state, w_next_state;
  logic r_enter_s, r_enter_q, r_lock_s, r_lock_q, r_armed;
  logic w_enter_edge, w_lock_edge;
  logic [15:0] r_attempt;
  logic [2:0]  r_fail_count, w_fail_next;
  logic w_bad, w_incomplete, w_clear, w_lock_load, w_hold_load;
  logic w_lock_expire, w_hold_expire, w_lock_en, w_hold_en;
  logic r_unlocked, r_locked_out, r_bad, r_incomplete, r_clear;
  logic [2:0] r_attempts_left;

  // On the first cycle out of reset the history copies the raw level, so a
  // button already held high must be released and pressed again to count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enter_s <= 1'b0;
      r_enter_q <= 1'b0;
      r_lock_s  <= 1'b0;
      r_lock_q  <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_enter_s <= bus.enterButton;
      r_lock_s  <= bus.lockButton;
      r_enter_q <= r_armed ? r_enter_s : bus.enterButton;
      r_lock_q  <= r_armed ? r_lock_s  : bus.lockButton;
      r_armed   <= 1'b1;
    end
  end

  assign w_enter_edge = r_enter_s & ~r_enter_q;
  assign w_lock_edge  = r_lock_s  & ~r_lock_q;
  assign w_lock_en    = (r_state == LOCKOUT);
  assign w_hold_en    = (r_state == UNLOCKED);

  cycle_timer #(.W(TIMER_W)) u_lock_timer (
    .clk(clk), .rst(rst), .i_load(w_lock_load), .i_load_value(LOCK_LOAD),
    .i_enable(w_lock_en), .o_expire(w_lock_expire)
  );

  cycle_timer #(.W(TIMER_W)) u_hold_timer (
    .clk(clk), .rst(rst), .i_load(w_hold_load), .i_load_value(HOLD_LOAD),
    .i_enable(w_hold_en), .o_expire(w_hold_expire)
  );

  always_comb begin
    w_next_state = r_state;
    w_fail_next  = r_fail_count;
    w_bad        = 1'b0;
    w_incomplete = 1'b0;
    w_clear      = 1'b0;
    w_lock_load  = 1'b0;
    w_hold_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enter_edge) begin
          if (has_blank(bus.passwordUnlockAttempt)) w_incomplete = 1'b1;
          else                                      w_next_state = COMPARE;
        end
      end
      COMPARE: begin
        w_clear = 1'b1;
        if (r_attempt == bus.storedPassword) begin
          w_next_state = UNLOCKED;
          w_fail_next  = 3'd0;
          w_hold_load  = HOLD_EN;
        end else begin
          w_bad       = 1'b1;
          w_fail_next = r_fail_count + 3'd1;
          if (w_fail_next >= MAX_A) begin
            w_next_state = LOCKOUT;
            w_lock_load  = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      UNLOCKED: begin
        if (w_lock_edge || (HOLD_EN && w_hold_expire)) w_next_state = IDLE;
      end
      LOCKOUT: begin
        if (w_lock_expire) begin
          w_next_state = IDLE;
          w_fail_next  = 3'd0;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_attempt       <= EMPTY_ATTEMPT;
      r_fail_count    <= 3'd0;
      r_unlocked      <= 1'b0;
      r_locked_out    <= 1'b0;
      r_bad           <= 1'b0;
      r_incomplete    <= 1'b0;
      r_clear         <= 1'b0;
      r_attempts_left <= MAX_A;
    end else begin
      r_state         <= w_next_state;
      if ((r_state == IDLE) && (w_next_state == COMPARE))
        r_attempt <= bus.passwordUnlockAttempt;
      r_fail_count    <= w_fail_next;
      r_unlocked      <= (w_next_state == UNLOCKED);
      r_locked_out    <= (w_next_state == LOCKOUT);
      r_bad           <= w_bad;
      r_incomplete    <= w_incomplete;
      r_clear         <= w_clear;
      r_attempts_left <= MAX_A - w_fail_next;
    end
  end

  assign bus.unlocked        = r_unlocked;
  assign bus.lockedOut       = r_locked_out;
  assign bus.badAttempt      = r_bad;
  assign bus.incompleteEntry = r_incomplete;
  assign bus.clearEntry      = r_clear;
  assign bus.attemptsLeft    = r_attempts_left;
  assign bus.checkState      = r_state;

endmodule
